csi_frame_mux: RTL
==================

// Module: csi_frame_mux
// PURPOSE
// - Multi-antenna successor to the single-stream CSI output path.
// - Merges N_CH per-antenna CSI streams (one equalizer output each) onto one AXIS stream for the DMA.
// - Each output frame is one header word followed by exactly FRAME_LEN CSI words.
// - Enforces frame length: short input frames are padded, long input frames are truncated.
// PARAMETERS
// N_CH       4       number of CSI input channels, 1..16
// DATA_W     32      word width, >=32; {re,im} packed as upstream
// FRAME_LEN  64      CSI words per frame (FFT bins)
// MAGIC      16'hC51D  header tag
// PORTS
// aclk           in   1            clock
// aresetn        in   1            synchronous reset, active-low
// s_axis_tvalid  in   N_CH         per-channel valid
// s_axis_tlast   in   N_CH         per-channel end of CSI frame
// s_axis_tdata   in   N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
// s_axis_tready  out  N_CH         per-channel ready
// ch_enable      in   N_CH         1 = channel eligible for arbitration
// m_axis_tvalid  out  1            output valid
// m_axis_tlast   out  1            last word of output frame
// m_axis_tdata   out  DATA_W       header or CSI word
// m_axis_tready  in   1            downstream ready
// frame_err      out  1            1-cycle pulse: length violation on the current frame
// err_count      out  16           saturating count of length violations
// BEHAVIOUR
// - One clock domain, aclk.
// - aresetn low at a posedge:
//   - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, frame_err=0, err_count=0.
//   - Internal: all seq counters=0, RR pointer=0, state=IDLE.
//   - A frame in flight is dropped without tlast; downstream must discard it.
// - Output register:
//   - Single output stage; it loads when (!m_axis_tvalid || m_axis_tready).
//   - m_axis_* hold stable while tvalid && !tready.
//   - Input-to-output latency is 1 cycle.
// - FSM: IDLE -> HDR -> DATA -> (PAD | DRAIN) -> IDLE.
// - IDLE:
//   - Requesting set = ch_enable & s_axis_tvalid.
//   - Round-robin grant g = first set bit at or after (last_grant+1) mod N_CH.
//   - Grant is locked until the frame completes. No set bit -> stay in IDLE.
// - HDR:
//   - Header word = {zero-extended, MAGIC[15:0], g[3:0], seq[g][11:0]}.
//   - Loaded when the output stage frees; then go to DATA with beat counter k=0.
//   - No input is consumed in HDR.
// - DATA:
//   - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready); all other s_axis_tready = 0.
//   - On each accepted beat, forward s_axis_tdata[g] and increment k.
//   - tlast on beat k==FRAME_LEN-1: normal end; m_axis_tlast=1; go to IDLE.
//   - tlast on beat k<FRAME_LEN-1 (short): forward the beat with m_axis_tlast=0; go to PAD.
//   - Beat k==FRAME_LEN-1 without tlast (long): m_axis_tlast=1; go to DRAIN.
// - PAD:
//   - Emit zero words, one per free output slot, until FRAME_LEN data words are out.
//   - The last zero word carries m_axis_tlast=1. No input is consumed.
// - DRAIN:
//   - s_axis_tready[g]=1; accept and discard beats through the next tlast on g; nothing is output.
//   - Then go to IDLE.
// - Errors:
//   - Entering PAD or DRAIN pulses frame_err one cycle.
//   - err_count increments on the same cycle and saturates at 16'hFFFF.
// - Sequence counters:
//   - seq[g] increments (mod 2^12) when the header for g is loaded.
//   - Counters are per channel and also advance on errored frames.
// - Grant and enable:
//   - last_grant updates to g on return to IDLE.
//   - ch_enable changes affect arbitration only, never a frame in progress.
// - Degenerate cases:
//   - N_CH=1 grants channel 0 whenever enabled.
//   - FRAME_LEN=1 with tlast on beat 0 is a normal frame.
// TESTING
// - Reset: hold aresetn=0 5 cycles with inputs toggling -> all outputs 0 and err_count=0 throughout.
// - Single channel:
//   - Stimulus: ch0 sends 64 words 0..63 with tlast on 63; m_axis_tready=1.
//   - Required: header 0xC51D0000, then 0..63, tlast on word 64; frame_err never pulses.
// - Round-robin:
//   - Stimulus: all 4 channels valid continuously, 3 frames each.
//   - Required: headers in ch order 0,1,2,3,0,1,...; ch1 seq fields 0,1,2.
// - Short frame:
//   - Stimulus: ch2 sends 10 words with tlast on word 9.
//   - Required: 10 data words, then 54 zeros, tlast on the last zero; frame_err=1 for one cycle; err_count=1.
// - Long frame:
//   - Stimulus: ch3 sends 70 words, tlast on word 69.
//   - Required: 64 words out with tlast on word 63; words 64..69 consumed and not output; err_count increments.
// - Backpressure and mid-frame reset:
//   - Stimulus: random m_axis_tready at 30%.
//   - Required: output identical to the ready=1 run; tdata/tlast stable while stalled.
//   - Stimulus: aresetn=0 at word 20.
//   - Required: next frame header has seq=0.

Source files
------------

// File: rtl/csi_frame_mux.sv
// Round-robin merge of N_CH per-antenna CSI streams into one AXIS stream of
// fixed-length frames: one header word, then FRAME_LEN words (padded or truncated).
module csi_frame_mux #(
  parameter int          N_CH      = 4,
  parameter int          DATA_W    = 32,
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] MAGIC     = 16'hC51D
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH-1:0]          s_axis_tvalid,
  input  logic [N_CH-1:0]          s_axis_tlast,
  input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
  output logic [N_CH-1:0]          s_axis_tready,
  input  logic [N_CH-1:0]          ch_enable,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [DATA_W-1:0]        m_axis_tdata,
  input  logic                     m_axis_tready,
  output logic                     frame_err,
  output logic [15:0]              err_count
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(N_CH - 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, DRAIN} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant, grant_n;
  logic [GW-1:0]   rr_ptr, rr_ptr_n;
  logic [GW-1:0]   rr_pick, grant_inc;
  logic            rr_hit;
  logic [KW-1:0]   k, k_n;
  logic [11:0]     seq [N_CH];
  logic [N_CH-1:0] req;
  logic [2*N_CH-1:0] req2;
  logic            ld, emit, emit_last, err, hdr_load;
  logic [DATA_W-1:0] emit_data, g_data, hdr_word;
  logic [31:0]     hdr_raw;
  logic            g_valid, g_last, k_end;

  assign ld        = !m_axis_tvalid || m_axis_tready;
  assign req       = ch_enable & s_axis_tvalid;
  assign g_valid   = s_axis_tvalid[grant];
  assign g_last    = s_axis_tlast[grant];
  assign g_data    = s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
  assign k_end     = (k == K_LAST);
  assign grant_inc = (grant == G_LAST) ? '0 : grant + 1'b1;
  assign hdr_raw   = {MAGIC, 4'(grant), seq[grant]};
  assign hdr_word  = DATA_W'(hdr_raw);

  // rr_ptr is the search start (last grant + 1); rotating a doubled request
  // vector keeps every bit select constant.
  always_comb begin
    int unsigned sum;
    rr_hit  = 1'b0;
    rr_pick = '0;
    sum     = 0;
    req2    = {req, req} >> rr_ptr;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!rr_hit && req2[i]) begin
        rr_hit = 1'b1;
        sum    = int'(rr_ptr) + i;
        if (sum >= N_CH) sum = sum - N_CH;
        rr_pick = GW'(sum);
      end
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    rr_ptr_n      = rr_ptr;
    k_n           = k;
    emit          = 1'b0;
    emit_last     = 1'b0;
    emit_data     = '0;
    err           = 1'b0;
    hdr_load      = 1'b0;
    s_axis_tready = '0;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          grant_n = rr_pick;
          state_n = HDR;
        end
      end
      HDR: begin
        if (ld) begin
          emit      = 1'b1;
          emit_data = hdr_word;
          hdr_load  = 1'b1;
          k_n       = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        s_axis_tready[grant] = ld;
        if (ld && g_valid) begin
          emit      = 1'b1;
          emit_data = g_data;
          k_n       = k + 1'b1;
          if (k_end) begin
            emit_last = 1'b1;
            if (g_last) begin
              state_n  = IDLE;
              rr_ptr_n = grant_inc;
            end else begin
              state_n = DRAIN;
              err     = 1'b1;
            end
          end else if (g_last) begin
            state_n = PAD;
            err     = 1'b1;
          end
        end
      end
      PAD: begin
        if (ld) begin
          emit = 1'b1;
          k_n  = k + 1'b1;
          if (k_end) begin
            emit_last = 1'b1;
            state_n   = IDLE;
            rr_ptr_n  = grant_inc;
          end
        end
      end
      DRAIN: begin
        s_axis_tready[grant] = 1'b1;
        if (g_valid && g_last) begin
          state_n  = IDLE;
          rr_ptr_n = grant_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    // No beat may be accepted in a cycle whose edge is about to reset the block.
    if (!aresetn) s_axis_tready = '0;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      k             <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      frame_err     <= 1'b0;
      err_count     <= '0;
      for (int unsigned c = 0; c < N_CH; c++) seq[c] <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      k         <= k_n;
      frame_err <= err;
      if (ld) begin
        m_axis_tvalid <= emit;
        m_axis_tlast  <= emit_last;
        if (emit) m_axis_tdata <= emit_data;
      end
      if (err && err_count != '1) err_count <= err_count + 1'b1;
      if (hdr_load) seq[grant] <= seq[grant] + 1'b1;
    end
  end

endmodule
